// File: rtl/sdio_data_pkg.sv
// Shared definitions for the SD4 data transfer sequencer: state encoding,
// the maximum block length and the 0-means-512 length normalisation.
package sdio_data_pkg;

   localparam int SDIO_MAX_BLOCK = 512;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ACTIVE,
      ST_RELEASE,
      ST_GAP,
      ST_DONE
   } state_t;

   // A length of 0 encodes a full 512-byte block; anything larger is clipped.
   function automatic logic [9:0] norm_len(input logic [9:0] len);
      if (len == 10'd0 || len > 10'(SDIO_MAX_BLOCK))
         return 10'(SDIO_MAX_BLOCK);
      return len;
   endfunction

endpackage

// File: rtl/sdio_data_timer.sv
// Loadable 16-bit down-counter shared by the inter-block gap and the block timeout.
// The counter holds at zero, and expired stays high while it does.
module sdio_data_timer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] load_val,
   input  logic        en,
   output logic        expired
);

   logic [15:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= 16'd0;
      else if (load)
         count <= load_val;
      else if (en && count != 16'd0)
         count <= count - 16'd1;
   end

   assign expired = (count == 16'd0);

endmodule

// File: rtl/sdio_data_seq.sv
// Splits one IO_RW_EXTENDED-style request into per-block PHY transactions,
// with inter-block gap, per-block timeout, abort and sticky completion status.
module sdio_data_seq
   import sdio_data_pkg::*;
#(
   parameter int GAP_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_start,
   input  logic       i_write,
   input  logic       i_block_mode,
   input  logic [9:0] i_block_size,
   input  logic [8:0] i_count,
   input  logic       i_abort,
   output logic       o_phy_activate,
   output logic       o_phy_write_flag,
   output logic [9:0] o_phy_data_count,
   input  logic       i_phy_finished,
   input  logic       i_phy_crc_err,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_crc_err,
   output logic       o_timeout,
   output logic       o_aborted,
   output logic [8:0] o_blocks_done,
   output state_t     dbg_state
);

   // Handshake: i_start is accepted only while o_busy is low; every accepted
   // start yields exactly one o_done pulse unless reset intervenes.

   localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES - 1);
   localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYCLES - 1);

   state_t      state;
   logic        cfg_block;
   logic [8:0]  cfg_count;
   logic        last_block;
   logic        tmr_load;
   logic        tmr_en;
   logic [15:0] tmr_val;
   logic        tmr_expired;

   // RELEASE arms the gap; LOAD and the end of GAP arm the block timeout.
   always_comb begin
      tmr_load = (state == ST_LOAD) || (state == ST_RELEASE) ||
                 (state == ST_GAP && tmr_expired);
      tmr_val  = (state == ST_RELEASE) ? GAP_LOAD : TMO_LOAD;
      tmr_en   = (state == ST_ACTIVE) || (state == ST_GAP);
   end

   sdio_data_timer u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .en       (tmr_en),
      .expired  (tmr_expired)
   );

   // Count 0 in block mode means run until aborted, so it is never last.
   assign last_block = !cfg_block || (cfg_count != 9'd0 && o_blocks_done == cfg_count);
   assign dbg_state  = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= ST_IDLE;
         cfg_block        <= 1'b0;
         cfg_count        <= 9'd0;
         o_phy_activate   <= 1'b0;
         o_phy_write_flag <= 1'b0;
         o_phy_data_count <= 10'd0;
         o_busy           <= 1'b0;
         o_done           <= 1'b0;
         o_crc_err        <= 1'b0;
         o_timeout        <= 1'b0;
         o_aborted        <= 1'b0;
         o_blocks_done    <= 9'd0;
      end else begin
         o_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  cfg_block        <= i_block_mode;
                  cfg_count        <= i_count;
                  o_phy_write_flag <= i_write;
                  o_phy_data_count <= i_block_mode ? norm_len(i_block_size)
                                                   : norm_len({1'b0, i_count});
                  o_crc_err        <= 1'b0;
                  o_timeout        <= 1'b0;
                  o_aborted        <= 1'b0;
                  o_blocks_done    <= 9'd0;
                  o_busy           <= 1'b1;
                  state            <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (i_abort) begin
                  o_aborted <= 1'b1;
                  o_done    <= 1'b1;
                  state     <= ST_DONE;
               end else begin
                  o_phy_activate <= 1'b1;
                  state          <= ST_ACTIVE;
               end
            end
            ST_ACTIVE: begin
               // A finishing block is always counted, even against abort or timeout.
               if (i_phy_finished) begin
                  o_phy_activate <= 1'b0;
                  o_blocks_done  <= o_blocks_done + 9'd1;
                  o_crc_err      <= o_crc_err | i_phy_crc_err;
                  if (i_abort) begin
                     o_aborted <= 1'b1;
                     o_done    <= 1'b1;
                     state     <= ST_DONE;
                  end else begin
                     state <= ST_RELEASE;
                  end
               end else if (i_abort) begin
                  o_phy_activate <= 1'b0;
                  o_aborted      <= 1'b1;
                  o_done         <= 1'b1;
                  state          <= ST_DONE;
               end else if (tmr_expired) begin
                  o_phy_activate <= 1'b0;
                  o_timeout      <= 1'b1;
                  o_done         <= 1'b1;
                  state          <= ST_DONE;
               end
            end
            ST_RELEASE: begin
               if (i_abort) begin
                  o_aborted <= 1'b1;
                  o_done    <= 1'b1;
                  state     <= ST_DONE;
               end else if (last_block || o_crc_err) begin
                  o_done <= 1'b1;
                  state  <= ST_DONE;
               end else begin
                  state <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (i_abort) begin
                  o_aborted <= 1'b1;
                  o_done    <= 1'b1;
                  state     <= ST_DONE;
               end else if (tmr_expired) begin
                  o_phy_activate <= 1'b1;
                  state          <= ST_ACTIVE;
               end
            end
            ST_DONE: begin
               o_phy_activate <= 1'b0;
               o_busy         <= 1'b0;
               state          <= ST_IDLE;
            end
            default: begin
               o_phy_activate <= 1'b0;
               o_busy         <= 1'b0;
               state          <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sdio_data_seq.sv
// Directed bench for sdio_data_seq: byte/block transfers, gaps, CRC stop,
// infinite-mode wrap with abort, timeout, async reset and ignored strobes.
module tb_sdio_data_seq;
   import sdio_data_pkg::*;

   localparam int GAP_CYCLES     = 2;
   localparam int TIMEOUT_CYCLES = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_start = 1'b0;
   logic       i_write = 1'b0;
   logic       i_block_mode = 1'b0;
   logic [9:0] i_block_size = 10'd0;
   logic [8:0] i_count = 9'd0;
   logic       i_abort = 1'b0;
   logic       i_phy_finished = 1'b0;
   logic       i_phy_crc_err = 1'b0;
   logic       o_phy_activate;
   logic       o_phy_write_flag;
   logic [9:0] o_phy_data_count;
   logic       o_busy;
   logic       o_done;
   logic       o_crc_err;
   logic       o_timeout;
   logic       o_aborted;
   logic [8:0] o_blocks_done;
   state_t     dbg_state;

   int         n_vec = 0;
   int         n_fail = 0;
   logic [8:0] exp_q[$];

   // ---- clock / reset ----
   always #5 clk = ~clk;

   sdio_data_seq #(
      .GAP_CYCLES     (GAP_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_start          (i_start),
      .i_write          (i_write),
      .i_block_mode     (i_block_mode),
      .i_block_size     (i_block_size),
      .i_count          (i_count),
      .i_abort          (i_abort),
      .o_phy_activate   (o_phy_activate),
      .o_phy_write_flag (o_phy_write_flag),
      .o_phy_data_count (o_phy_data_count),
      .i_phy_finished   (i_phy_finished),
      .i_phy_crc_err    (i_phy_crc_err),
      .o_busy           (o_busy),
      .o_done           (o_done),
      .o_crc_err        (o_crc_err),
      .o_timeout        (o_timeout),
      .o_aborted        (o_aborted),
      .o_blocks_done    (o_blocks_done),
      .dbg_state        (dbg_state)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish before 500000ns");
      $fatal(1);
   end

   // ---- driver tasks ----
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   // Presents a request for one cycle; returns at the LOAD-state sample point.
   task automatic start_xfer(input logic wr, input logic blk, input logic [9:0] size,
                             input logic [8:0] cnt);
      i_write      = wr;
      i_block_mode = blk;
      i_block_size = size;
      i_count      = cnt;
      i_start      = 1'b1;
      cyc();
      i_start      = 1'b0;
   endtask

   // Called with activate high: pulses finished, then counts low cycles until
   // the next activate window or o_done (low=99 if neither shows up).
   task automatic run_block(input logic crc, output int low, output logic done);
      logic found;
      low   = 0;
      done  = 1'b0;
      found = 1'b0;
      i_phy_finished = 1'b1;
      i_phy_crc_err  = crc;
      cyc();
      i_phy_finished = 1'b0;
      i_phy_crc_err  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (o_phy_activate || o_done) begin
            done  = o_done;
            found = 1'b1;
            break;
         end
         low++;
         cyc();
      end
      if (!found) low = 99;
   endtask

   // ---- scoreboard: expected blocks_done per completion ----
   task automatic check_done(input string tag);
      chk({tag, "_done"}, o_done, 1'b1);
      if (exp_q.size() == 0)
         chk({tag, "_sb_underflow"}, 1, 0);
      else
         chk({tag, "_blocks"}, o_blocks_done, exp_q.pop_front());
   endtask

   initial begin
      int   low;
      logic done;
      int   bad;
      int   hi;
      logic seen;

      // Reset state
      #2;
      chk("rst_activate", o_phy_activate, 1'b0);
      chk("rst_status", {o_busy, o_done, o_crc_err, o_timeout, o_aborted}, 5'b0);
      chk("rst_blocks", o_blocks_done, 9'd0);
      chk("rst_phy_cfg", {o_phy_write_flag, o_phy_data_count}, 11'd0);
      chk("rst_state", dbg_state, ST_IDLE);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cyc();

      // 1: byte-mode read of 4 bytes
      exp_q.push_back(9'd1);
      start_xfer(1'b0, 1'b0, 10'd0, 9'd4);
      chk("t1_load_act", o_phy_activate, 1'b0);
      chk("t1_dcount", o_phy_data_count, 10'd4);
      chk("t1_wflag", o_phy_write_flag, 1'b0);
      chk("t1_busy", o_busy, 1'b1);
      cyc();
      chk("t1_act_lat", o_phy_activate, 1'b1);
      run_block(1'b0, low, done);
      chk("t1_done_lat", low, 1);
      check_done("t1");
      chk("t1_errs", {o_crc_err, o_timeout, o_aborted}, 3'b0);
      cyc();
      chk("t1_idle", {o_busy, o_done}, 2'b0);

      // 2: block-mode write, size 0 -> 512, three blocks
      exp_q.push_back(9'd3);
      start_xfer(1'b1, 1'b1, 10'd0, 9'd3);
      chk("t2_dcount", o_phy_data_count, 10'd512);
      chk("t2_wflag", o_phy_write_flag, 1'b1);
      cyc();
      chk("t2_act", o_phy_activate, 1'b1);
      for (int b = 0; b < 2; b++) begin
         run_block(1'b0, low, done);
         chk("t2_gap_low", low, 3);
         chk("t2_no_early_done", done, 1'b0);
         chk("t2_dcount_held", o_phy_data_count, 10'd512);
      end
      run_block(1'b0, low, done);
      chk("t2_last_low", low, 1);
      check_done("t2");
      cyc();
      chk("t2_single_done", {o_busy, o_done}, 2'b0);

      // 3: CRC error on block 2 of 5; size 700 clips to 512
      exp_q.push_back(9'd2);
      start_xfer(1'b0, 1'b1, 10'd700, 9'd5);
      chk("t3_clip", o_phy_data_count, 10'd512);
      cyc();
      run_block(1'b0, low, done);
      chk("t3_gap_low", low, 3);
      run_block(1'b1, low, done);
      chk("t3_stop_low", low, 1);
      check_done("t3");
      chk("t3_crc", o_crc_err, 1'b1);
      cyc();

      // 4: infinite block mode, 600 blocks then abort in GAP
      exp_q.push_back(9'd89);
      start_xfer(1'b0, 1'b1, 10'd64, 9'd0);
      chk("t4_dcount", o_phy_data_count, 10'd64);
      cyc();
      bad = 0;
      for (int b = 0; b < 600; b++) begin
         run_block(1'b0, low, done);
         if (low != 3 || done) bad++;
      end
      chk("t4_inf_gaps", bad, 0);
      chk("t4_wrap", o_blocks_done, 9'd88);
      chk("t4_act", o_phy_activate, 1'b1);
      i_phy_finished = 1'b1;
      cyc();
      i_phy_finished = 1'b0;
      cyc();
      chk("t4_in_gap", dbg_state, ST_GAP);
      i_abort = 1'b1;
      cyc();
      chk("t4_abort_act", o_phy_activate, 1'b0);
      chk("t4_aborted", o_aborted, 1'b1);
      check_done("t4");
      i_abort = 1'b0;
      cyc();

      // 5: timeout after 10 active cycles, cleared by next start
      exp_q.push_back(9'd0);
      start_xfer(1'b0, 1'b1, 10'd16, 9'd1);
      cyc();
      hi = 0;
      while (o_phy_activate && hi < 50) begin
         hi++;
         cyc();
      end
      chk("t5_active_len", hi, 10);
      check_done("t5");
      chk("t5_timeout", o_timeout, 1'b1);
      cyc();
      exp_q.push_back(9'd1);
      start_xfer(1'b0, 1'b1, 10'd16, 9'd1);
      chk("t5_tmo_cleared", o_timeout, 1'b0);
      cyc();
      run_block(1'b0, low, done);
      chk("t5b_low", low, 1);
      check_done("t5b");
      cyc();

      // 6: async reset mid-ACTIVE; byte count 0 -> 512
      start_xfer(1'b1, 1'b0, 10'd0, 9'd0);
      chk("t6_dcount512", o_phy_data_count, 10'd512);
      cyc();
      chk("t6_act", o_phy_activate, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_rst_act", o_phy_activate, 1'b0);
      chk("t6_rst_busy", o_busy, 1'b0);
      cyc();
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         seen = seen | o_done;
      end
      chk("t6_no_done", seen, 1'b0);

      // 7: i_start while busy ignored, finished in IDLE ignored
      exp_q.push_back(9'd1);
      start_xfer(1'b0, 1'b0, 10'd0, 9'd2);
      cyc();
      i_start = 1'b1;
      i_write = 1'b1;
      i_count = 9'd9;
      cyc();
      i_start = 1'b0;
      chk("t7_wflag_held", o_phy_write_flag, 1'b0);
      chk("t7_dcount_held", o_phy_data_count, 10'd2);
      run_block(1'b0, low, done);
      check_done("t7");
      cyc();
      i_phy_finished = 1'b1;
      cyc();
      i_phy_finished = 1'b0;
      chk("t7_idle_fin_busy", o_busy, 1'b0);
      chk("t7_idle_fin_blocks", o_blocks_done, 9'd1);
      chk("t7_idle_state", dbg_state, ST_IDLE);
      cyc();
      chk("t7_idle_no_done", o_done, 1'b0);

      chk("sb_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
